// File: rtl/ram_bus_controller.sv
// ram_bus_controller
//   Sequencer in front of a 4-bit x 256-nibble shared-bus RAM. Accepts
//   single-nibble writes and burst reads from the CPU core over a valid/ready
//   handshake. It drives the RAM address and write-enable lines, owns the
//   tri-state data bus only while writing, and returns each captured read
//   nibble with a one-cycle rd_valid strobe.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   req_valid/ready   request handshake; transfer on valid && ready at posedge
//   req_write         1 = single-nibble write, 0 = burst read
//   req_addr          start address
//   req_len           read beats minus one (ignored on writes)
//   req_wdata         write nibble
//   rd_data/rd_valid  captured read nibble and its one-cycle strobe
//   wr_done           one-cycle pulse after a write completes
//   mem_addr/mem_we   RAM address and write-enable
//   mem_data          RAM data bus; driven only while mem_we is high
`timescale 1ns/1ps

module ram_bus_controller #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 4,
   parameter int TURNAROUND = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [3:0]        req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              wr_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   inout  wire  [DATA_W-1:0] mem_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_TURN,
      S_RD_SETUP,
      S_RD_CAP
   } state_t;

   // TURN is entered holding TURNAROUND-1 and left once the count hits zero,
   // so it lasts exactly TURNAROUND cycles.
   localparam logic [1:0] TURN_INIT = 2'(TURNAROUND - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          beat_q, beat_d;
   logic [1:0]          turn_q, turn_d;
   logic                mem_we_q, mem_we_d;
   logic                req_ready_q, req_ready_d;
   logic                rd_valid_q, rd_valid_d;
   logic                wr_done_q, wr_done_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      beat_d      = beat_q;
      turn_d      = turn_q;
      mem_we_d    = 1'b0;
      req_ready_d = req_ready_q;
      rd_valid_d  = 1'b0;
      wr_done_d   = 1'b0;
      rd_data_d   = rd_data_q;

      unique case (state_q)
         S_IDLE: begin
            // req_ready_q is high throughout IDLE, so valid alone is an accept.
            if (req_valid) begin
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               beat_d      = req_len;
               req_ready_d = 1'b0;
               if (req_write) begin
                  state_d  = S_WR;
                  mem_we_d = 1'b1;
               end else begin
                  state_d  = S_RD_SETUP;
               end
            end
         end

         S_WR: begin
            // The RAM has taken the nibble at the mid-cycle negedge.
            wr_done_d = 1'b1;
            if (TURNAROUND > 0) begin
               state_d = S_TURN;
               turn_d  = TURN_INIT;
            end else begin
               state_d     = S_IDLE;
               req_ready_d = 1'b1;
            end
         end

         S_TURN: begin
            if (turn_q == 2'd0) begin
               state_d     = S_IDLE;
               req_ready_d = 1'b1;
            end else begin
               turn_d = turn_q - 2'd1;
            end
         end

         S_RD_SETUP: begin
            // RAM latches memory[addr] at the closing edge of this cycle.
            state_d = S_RD_CAP;
         end

         S_RD_CAP: begin
            rd_data_d  = mem_data;
            rd_valid_d = 1'b1;
            if (beat_q != 4'd0) begin
               beat_d  = beat_q - 4'd1;
               addr_d  = addr_q + 1'b1;   // wraps modulo 2**ADDR_W
               state_d = S_RD_SETUP;
            end else begin
               state_d     = S_IDLE;
               req_ready_d = 1'b1;
            end
         end

         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         beat_q      <= 4'd0;
         turn_q      <= 2'd0;
         mem_we_q    <= 1'b0;
         req_ready_q <= 1'b1;
         rd_valid_q  <= 1'b0;
         wr_done_q   <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         beat_q      <= beat_d;
         turn_q      <= turn_d;
         mem_we_q    <= mem_we_d;
         req_ready_q <= req_ready_d;
         rd_valid_q  <= rd_valid_d;
         wr_done_q   <= wr_done_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Bus enable is the registered write-enable itself, so the controller can
   // never drive while the RAM sees mem_we low and is driving its read data.
   assign mem_data  = mem_we_q ? wdata_q : {DATA_W{1'bz}};

   assign mem_addr  = addr_q;
   assign mem_we    = mem_we_q;
   assign req_ready = req_ready_q;
   assign rd_valid  = rd_valid_q;
   assign wr_done   = wr_done_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_ram_bus_controller.sv
// Testbench for ram_bus_controller: table-driven requests against a
// behavioural shared-bus RAM, a read-data scoreboard, plus hand-written
// sequences for burst wrap, turnaround back-to-back and mid-burst reset.
`timescale 1ns/1ps

module tb_ram_bus_controller;

   localparam int TURNAROUND = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [3:0] req_len = 4'h0;
   logic [3:0] req_wdata = 4'h0;
   logic       req_ready;
   logic [3:0] rd_data;
   logic       rd_valid;
   logic       wr_done;
   logic [7:0] mem_addr;
   logic       mem_we;
   wire  [3:0] mem_data;

   always #5 clk = ~clk;

   ram_bus_controller #(
      .ADDR_W(8), .DATA_W(4), .TURNAROUND(TURNAROUND)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
      .rd_data(rd_data), .rd_valid(rd_valid), .wr_done(wr_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_data(mem_data)
   );

   // Behavioural RAM: latches memory[addr] on posedge while not writing,
   // drives it whenever mem_we is low, writes at the negedge when mem_we high.
   logic [3:0] ram [0:255];
   logic [3:0] ram_q = 4'h0;
   assign mem_data = mem_we ? 4'bzzzz : ram_q;
   always @(posedge clk) if (!mem_we) ram_q <= ram[mem_addr];
   always @(negedge clk) if (mem_we) ram[mem_addr] <= mem_data;

   // Reference contents and scoreboard state
   logic [3:0] model [0:255];
   logic [3:0] sb_q [$];
   int         rd_cyc [$];
   logic [7:0] addr_trace [$];
   int         cyc = 0;
   int         n_vec = 0;
   int         n_err = 0;
   int         wr_done_seen = 0;
   int         exp_wr_cnt = 0;
   int         acc_cyc = 0;
   logic [7:0] exp_wr_addr = 8'h00;
   logic [3:0] exp_wr_data = 4'h0;
   logic [3:0] exp_nib;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Output monitor / scoreboard, sampled on the inactive edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_valid) begin
            rd_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
               chk("rd_unexpected_beat", {28'h0, rd_data}, 32'hFFFF_FFFF);
            end else begin
               exp_nib = sb_q.pop_front();
               chk("rd_data", {28'h0, rd_data}, {28'h0, exp_nib});
            end
         end
         if (wr_done) wr_done_seen++;
         if (mem_we) begin
            chk("wr_bus_addr", {24'h0, mem_addr}, {24'h0, exp_wr_addr});
            chk("wr_bus_data", {28'h0, mem_data}, {28'h0, exp_wr_data});
         end
         chk("bus_not_x", {31'h0, ^mem_data === 1'bx}, 32'h0);
      end
   end

   // One request: wait for ready, accept, scramble req_* while busy, then
   // measure how many cycles req_ready stays low.
   task automatic do_req(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                         input logic [3:0] wd, input int exp_busy);
      int guard;
      int busy;
      int wd0;
      @(negedge clk);
      req_write = wr; req_addr = addr; req_len = len; req_wdata = wd; req_valid = 1'b1;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         chk("accept_timeout", 32'(guard), 32'd0);
         req_valid = 1'b0;
         return;
      end
      wd0 = wr_done_seen;
      if (wr) begin
         model[addr] = wd; exp_wr_addr = addr; exp_wr_data = wd; exp_wr_cnt++;
      end else begin
         for (int k = 0; k <= int'(len); k++) sb_q.push_back(model[8'(int'(addr) + k)]);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      req_valid = 1'b0;
      // Requests changed while busy must not affect the transfer in flight
      req_addr = 8'($urandom); req_wdata = 4'($urandom);
      req_len = 4'($urandom); req_write = 1'($urandom);
      addr_trace.delete();
      busy = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && busy < 100) begin
         addr_trace.push_back(mem_addr);
         busy++;
         @(negedge clk);
      end
      #1;
      chk(wr ? "busy_write" : "busy_read", 32'(busy), 32'(exp_busy));
      chk("wr_done_pulses", 32'(wr_done_seen - wd0), wr ? 32'd1 : 32'd0);
   endtask

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [3:0] len;
      logic [3:0] wdata;
      int         exp_busy;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int g;
      int acc;
      logic [7:0] exp_tr [8];

      for (int i = 0; i < 256; i++) begin
         ram[i] <= 4'(i) ^ 4'h5;
         model[i] = 4'(i) ^ 4'h5;
      end

      tbl[0] = '{1'b1, 8'hFE, 4'd0, 4'h1, 2};
      tbl[1] = '{1'b1, 8'hFF, 4'd0, 4'h2, 2};
      tbl[2] = '{1'b1, 8'h00, 4'd0, 4'h3, 2};
      tbl[3] = '{1'b1, 8'h01, 4'd0, 4'h4, 2};
      tbl[4] = '{1'b1, 8'h05, 4'd5, 4'h9, 2};   // len ignored on write
      tbl[5] = '{1'b0, 8'h05, 4'd0, 4'h0, 2};
      tbl[6] = '{1'b0, 8'h00, 4'd1, 4'h0, 4};
      tbl[7] = '{1'b1, 8'h80, 4'd0, 4'hF, 2};
      tbl[8] = '{1'b0, 8'h7F, 4'd2, 4'h0, 6};
      tbl[9] = '{1'b0, 8'hF8, 4'd15, 4'h0, 32}; // 16 beats, wraps past 0xFF

      // Reset values
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
      chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
      chk("rst_rd_valid", {31'h0, rd_valid}, 32'd0);
      chk("rst_wr_done", {31'h0, wr_done}, 32'd0);
      chk("rst_mem_addr", {24'h0, mem_addr}, 32'd0);
      chk("rst_rd_data", {28'h0, rd_data}, 32'd0);
      chk("rst_bus_released", {28'h0, mem_data}, {28'h0, ram_q});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Sequence 1: write 0xA @0x3C then single-beat read
      do_req(1'b1, 8'h3C, 4'd0, 4'hA, 1 + TURNAROUND);
      rd_cyc.delete();
      do_req(1'b0, 8'h3C, 4'd0, 4'h0, 2);
      chk("t1_beats", 32'(rd_cyc.size()), 32'd1);
      if (rd_cyc.size() > 0) chk("t1_beat_time", 32'(rd_cyc[0]), 32'(acc_cyc + 2));
      chk("t1_rd_data", {28'h0, rd_data}, 32'hA);

      // Table-driven vectors (includes preload of 0xFE..0x01)
      for (int i = 0; i < 10; i++)
         do_req(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].wdata, tbl[i].exp_busy);

      // Sequence 2: wrapping burst read @0xFE len=3
      rd_cyc.delete();
      do_req(1'b0, 8'hFE, 4'd3, 4'h0, 8);
      exp_tr = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01};
      chk("t2_trace_len", 32'(addr_trace.size()), 32'd8);
      for (int i = 0; i < 8 && i < addr_trace.size(); i++)
         chk("t2_mem_addr", {24'h0, addr_trace[i]}, {24'h0, exp_tr[i]});
      chk("t2_beats", 32'(rd_cyc.size()), 32'd4);
      if (rd_cyc.size() > 0) chk("t2_first_beat", 32'(rd_cyc[0]), 32'(acc_cyc + 2));
      for (int i = 1; i < rd_cyc.size(); i++)
         chk("t2_beat_spacing", 32'(rd_cyc[i] - rd_cyc[i-1]), 32'd2);
      chk("t2_last_data", {28'h0, rd_data}, 32'h4);

      // Sequence 3: write then read with req_valid held high
      rd_cyc.delete();
      @(negedge clk);
      chk("t3_idle_ready", {31'h0, req_ready}, 32'd1);
      req_write = 1'b1; req_addr = 8'h40; req_wdata = 4'h6; req_len = 4'd0; req_valid = 1'b1;
      model[8'h40] = 4'h6; exp_wr_addr = 8'h40; exp_wr_data = 4'h6; exp_wr_cnt++;
      @(posedge clk); #1;
      acc = cyc;
      req_write = 1'b0;
      @(negedge clk); chk("t3_ready_wr", {31'h0, req_ready}, 32'd0);
      @(negedge clk); chk("t3_ready_turn", {31'h0, req_ready}, 32'd0);
      @(negedge clk); chk("t3_ready_back", {31'h0, req_ready}, 32'd1);
      sb_q.push_back(model[8'h40]);
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("t3_beats", 32'(rd_cyc.size()), 32'd1);
      if (rd_cyc.size() > 0) chk("t3_beat_time", 32'(rd_cyc[0]), 32'(acc + 5));

      // Random mixed traffic
      for (int i = 0; i < 40; i++) begin
         bit         w;
         logic [3:0] l;
         w = 1'($urandom_range(0, 1));
         l = 4'($urandom_range(0, 3));
         do_req(w, 8'h30 + 8'($urandom_range(0, 15)), l, 4'($urandom),
                w ? 1 + TURNAROUND : 2 * (int'(l) + 1));
      end

      // Sequence 4: reset after beat 1 of an 8-beat burst
      rd_cyc.delete();
      @(negedge clk);
      req_write = 1'b0; req_addr = 8'h10; req_len = 4'd7; req_valid = 1'b1;
      for (int k = 0; k < 8; k++) sb_q.push_back(model[8'h10 + 8'(k)]);
      @(posedge clk); #1;
      req_valid = 1'b0;
      g = 0;
      while (sb_q.size() > 6 && g < 50) begin
         @(negedge clk); #1;
         g++;
      end
      chk("t4_beat_wait", {31'h0, g >= 50}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t4_mem_we", {31'h0, mem_we}, 32'd0);
      chk("t4_rd_valid", {31'h0, rd_valid}, 32'd0);
      chk("t4_bus_released", {28'h0, mem_data}, {28'h0, ram_q});
      chk("t4_mem_addr", {24'h0, mem_addr}, 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk("t4_ready_after", {31'h0, req_ready}, 32'd1);
      chk("t4_no_more_beats", 32'(rd_cyc.size()), 32'd2);

      // Post-reset sanity: write/read still functional
      do_req(1'b1, 8'h22, 4'd0, 4'hC, 1 + TURNAROUND);
      do_req(1'b0, 8'h22, 4'd0, 4'h0, 2);

      repeat (4) @(negedge clk);
      #1;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      chk("wr_done_total", 32'(wr_done_seen), 32'(exp_wr_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
